// File: rtl/fir_out_pkg.sv
// Shared types and widths for the FIR output serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_out_pkg;

    // Result width of the FIR core and width of the output pin bus;
    // the top-level wrapper uses the same constants.
    localparam int FIR_Y_W    = 16;
    localparam int OUT_BYTE_W = 8;

    // Serializer states: IDLE (nothing to send), HI (high byte on the bus),
    // LO (low byte on the bus).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/fir_out_serializer_fifo.sv
// Purpose: synchronous word FIFO; head word visible on dout whenever !empty.
// Latency: a word pushed at edge N is readable (empty=0) after edge N; no bypass.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, level.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign level = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        // When full, the slot being popped this cycle is the one written.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only observed behind cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Purpose: buffer FIR results and send each as two bytes (high first) on a valid/ready stream.
// Latency: y_vld at edge N -> pop at edge N+1 -> high byte valid after edge N+1.
// Backpressure: out_rdy low stalls the byte in place; FIFO absorbs DEPTH words, extras drop and set ovf.
// Ports: clk, rst (sync, active-high); y_dat/y_vld from the FIR core;
//        out_byte/out_vld/out_rdy/out_last byte stream; ovf sticky drop flag; level FIFO occupancy.
module fir_out_serializer
    import fir_out_pkg::*;
#(
    parameter int DATA_W = FIR_Y_W,
    parameter int BYTE_W = OUT_BYTE_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       y_dat,
    input  logic                    y_vld,
    output logic [BYTE_W-1:0]       out_byte,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    out_last,
    output logic                    ovf,
    output logic [$clog2(DEPTH):0]  level
);

    ser_state_t          state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [BYTE_W-1:0]   out_byte_q, out_byte_d;
    logic                out_vld_q, out_vld_d;
    logic                out_last_q, out_last_d;
    logic                ovf_q, ovf_d;

    logic                hs;
    logic                fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_dout;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (y_dat),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        hs       = out_vld_q && out_rdy;
        state_d  = state_q;
        hold_d   = hold_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_dout;
                    state_d  = HI;
                end
            end
            HI: begin
                if (hs) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (hs) begin
                    // Reload straight from the FIFO so words leave with no bubble.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = fifo_dout;
                        state_d  = HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop this cycle frees a slot, so a full FIFO still takes the word.
        fifo_push = y_vld && (!fifo_full || fifo_pop);
        ovf_d     = ovf_q || (y_vld && !fifo_push);

        // Outputs are registered from the next state, so out_rdy never
        // reaches out_vld/out_byte combinationally.
        out_vld_d  = (state_d != IDLE);
        out_last_d = (state_d == LO);
        out_byte_d = '0;
        if (state_d == HI) begin
            out_byte_d = hold_d[DATA_W-1:BYTE_W];
        end else if (state_d == LO) begin
            out_byte_d = hold_d[BYTE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            out_byte_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            out_byte_q <= out_byte_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_byte = out_byte_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Bench for fir_out_serializer: word-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fir_out_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] y_dat;
    logic        y_vld;
    logic [7:0]  out_byte;
    logic        out_vld;
    logic        out_rdy;
    logic        out_last;
    logic        ovf;
    logic [2:0]  level;

    fir_out_serializer #(
        .DATA_W (16),
        .BYTE_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .y_dat    (y_dat),
        .y_vld    (y_vld),
        .out_byte (out_byte),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .ovf      (ovf),
        .level    (level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The word currently on the bus (if any), which half of it is showing,
    // and a queue of words still waiting.
    logic [15:0] m_fifo[$];
    logic [15:0] m_cur;
    logic        m_cur_v;
    logic        m_pos;      // 0: high byte showing, 1: low byte showing
    logic        m_ovf;
    bit          started = 0;

    always @(posedge clk) begin : model
        bit accept, want_next, take, was_full;
        if (rst) begin
            m_fifo.delete();
            m_cur   = '0;
            m_cur_v = 1'b0;
            m_pos   = 1'b0;
            m_ovf   = 1'b0;
            started = 1;
        end else begin
            accept    = m_cur_v && out_rdy;
            // A new word is needed when nothing is showing or the low byte just left.
            want_next = !m_cur_v || (accept && m_pos);
            take      = want_next && (m_fifo.size() > 0);
            was_full  = (m_fifo.size() == DEPTH);
            if (accept && !m_pos) m_pos = 1'b1;
            if (want_next) begin
                if (take) begin
                    m_cur   = m_fifo.pop_front();
                    m_cur_v = 1'b1;
                    m_pos   = 1'b0;
                end else begin
                    m_cur_v = 1'b0;
                    m_pos   = 1'b0;
                end
            end
            if (y_vld) begin
                if (!was_full || take) m_fifo.push_back(y_dat);
                else m_ovf = 1'b1;
            end
        end
    end

    // Accepted bytes, in order, for the directed checks.
    logic [7:0] byte_log[$];

    always @(negedge clk) begin : compare
        logic [7:0] exp_byte;
        if (started) begin
            exp_byte = !m_cur_v ? 8'h00 : (m_pos ? m_cur[7:0] : m_cur[15:8]);
            chk("model_out_vld",  out_vld,  m_cur_v);
            chk("model_out_byte", out_byte, exp_byte);
            chk("model_out_last", out_last, m_cur_v && m_pos);
            chk("model_ovf",      ovf,      m_ovf);
            chk("model_level",    level,    m_fifo.size());
            if (out_vld === 1'b1 && out_rdy === 1'b1) byte_log.push_back(out_byte);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_count"}, byte_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < byte_log.size()) chk(name, byte_log[i], exp_q[i]);
        end
    endtask

    initial begin : stim
        logic [7:0] exp_q[$];
        int run, maxrun;
        int vrate, rrate;

        rst = 1'b1; y_vld = 1'b0; y_dat = '0; out_rdy = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_out_vld",  out_vld,  1'b0);
        chk("reset_out_byte", out_byte, 8'h00);
        chk("reset_ovf",      ovf,      1'b0);
        chk("reset_level",    level,    3'd0);

        // Reset mid-stream discards everything buffered or in flight.
        y_vld = 1'b1; y_dat = 16'hDD01; step();
        y_dat = 16'hDD02; step();
        y_dat = 16'hDD03; step();
        y_vld = 1'b0; out_rdy = 1'b1;
        rst = 1'b1; step(); step();
        rst = 1'b0;
        chk("midrst_out_vld",  out_vld,  1'b0);
        chk("midrst_out_byte", out_byte, 8'h00);
        chk("midrst_level",    level,    3'd0);
        byte_log.delete();
        repeat (5) step();
        chk("midrst_no_old_bytes", byte_log.size(), 0);

        // Single word, out_rdy high.
        y_dat = 16'hA55A; y_vld = 1'b1; step();
        y_vld = 1'b0;
        chk("single_level_after_push", level, 3'd1);
        chk("single_not_yet_valid", out_vld, 1'b0);
        step();
        chk("single_hi_vld",  out_vld,  1'b1);
        chk("single_hi_byte", out_byte, 8'hA5);
        chk("single_hi_last", out_last, 1'b0);
        step();
        chk("single_lo_vld",  out_vld,  1'b1);
        chk("single_lo_byte", out_byte, 8'h5A);
        chk("single_lo_last", out_last, 1'b1);
        step();
        chk("single_idle_after", out_vld, 1'b0);

        // Backpressure holds the high byte steady.
        out_rdy = 1'b0;
        y_dat = 16'h1234; y_vld = 1'b1; step();
        y_vld = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld",  out_vld,  1'b1);
            chk("stall_byte", out_byte, 8'h12);
            step();
        end
        out_rdy = 1'b1;
        chk("release_byte_hi", out_byte, 8'h12);
        step();
        chk("release_byte_lo", out_byte, 8'h34);
        chk("release_last",    out_last, 1'b1);
        step();

        // Fill to overflow with the consumer stalled.
        out_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            y_dat = 16'(i); y_vld = 1'b1; step();
        end
        y_vld = 1'b0;
        chk("fill_level", level, 3'd4);
        chk("fill_ovf",   ovf,   1'b1);
        byte_log.delete();
        out_rdy = 1'b1;
        repeat (12) step();
        exp_q = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
        chk_log("drain_bytes", exp_q);
        chk("drain_ovf_sticky", ovf, 1'b1);

        // Back-to-back words leave with no idle cycle.
        rst = 1'b1; step(); rst = 1'b0;
        byte_log.delete();
        run = 0; maxrun = 0;
        for (int i = 0; i < 12; i++) begin
            y_vld = (i < 3);
            y_dat = 16'hAB01 + 16'(i);
            step();
            if (out_vld) run++; else run = 0;
            if (run > maxrun) maxrun = run;
        end
        y_vld = 1'b0;
        chk("b2b_run_len", maxrun, 6);
        exp_q = {8'hAB, 8'h01, 8'hAB, 8'h02, 8'hAB, 8'h03};
        chk_log("b2b_bytes", exp_q);

        // Push into a full FIFO while the LO handshake pops.
        rst = 1'b1; step(); rst = 1'b0;
        out_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            y_dat = 16'hC000 + 16'(i); y_vld = 1'b1; step();
        end
        y_vld = 1'b0;
        chk("fullpop_level_before", level, 3'd4);
        byte_log.delete();
        out_rdy = 1'b1; step();
        y_dat = 16'hC006; y_vld = 1'b1; step();
        y_vld = 1'b0;
        chk("fullpop_level", level, 3'd4);
        chk("fullpop_ovf",   ovf,   1'b0);
        repeat (14) step();
        exp_q = {8'hC0, 8'h01, 8'hC0, 8'h02, 8'hC0, 8'h03,
                 8'hC0, 8'h04, 8'hC0, 8'h05, 8'hC0, 8'h06};
        chk_log("fullpop_bytes", exp_q);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            vrate = $urandom_range(10, 90);
            rrate = $urandom_range(10, 100);
            for (int c = 0; c < 500; c++) begin
                rst     = ($urandom_range(0, 299) == 0);
                y_vld   = ($urandom_range(0, 99) < vrate);
                y_dat   = 16'($urandom);
                out_rdy = ($urandom_range(0, 99) < rrate);
                step();
            end
        end
        rst = 1'b0; y_vld = 1'b0; out_rdy = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
